// File: rtl/program_counter_mt_pkg.sv
// -----------------------------------------------------------------------------
// program_counter_mt_pkg
//   Shared definitions for the multi-thread program counter:
//   - ITER_INF : iteration-limit encoding meaning "run forever"
//   - tid_width: width of a thread index for a given thread count
// -----------------------------------------------------------------------------
package program_counter_mt_pkg;

  // An iteration limit of zero disables the done condition.
  localparam int ITER_INF = 0;

  // Thread-id width; a single bit is kept even for degenerate counts so that
  // slot and pc_tid never collapse to zero-width vectors.
  function automatic int tid_width(input int num_threads);
    return (num_threads > 1) ? $clog2(num_threads) : 1;
  endfunction

endpackage

// File: rtl/program_counter_mt_pc_thread_ctx.sv
// -----------------------------------------------------------------------------
// pc_thread_ctx
//   One program-counter context. Holds its configuration (max, loop, iters),
//   the next pc to emit, the wrap counter and the active/done state. Advances
//   only when selected by the top-level slot rotation.
// Ports
//   clk, rst        clock / synchronous active-high reset
//   sel             this context owns the current slot and en is high
//   start           start pulse for this context
//   cfg_we          configuration write addressed to this context
//   cfg_max/loop    last pc of a pass / restart pc after max
//   cfg_iters       number of wraps before done (ITER_INF = forever)
//   active          context is running
//   done            sticky done flag, cleared by start
//   nxt             pc value emitted on the next selected slot
// -----------------------------------------------------------------------------
module pc_thread_ctx
  import program_counter_mt_pkg::*;
#(
  parameter int PC_WIDTH   = 8,
  parameter int ITER_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel,
  input  logic                  start,
  input  logic                  cfg_we,
  input  logic [PC_WIDTH-1:0]   cfg_max,
  input  logic [PC_WIDTH-1:0]   cfg_loop,
  input  logic [ITER_WIDTH-1:0] cfg_iters,
  output logic                  active,
  output logic                  done,
  output logic [PC_WIDTH-1:0]   nxt
);

  logic [PC_WIDTH-1:0]   max_q;
  logic [PC_WIDTH-1:0]   loop_q;
  logic [ITER_WIDTH-1:0] iters_q;
  logic [ITER_WIDTH-1:0] iter_cnt_q;

  logic                  wrap;
  logic [ITER_WIDTH-1:0] iter_next;
  logic                  last_pass;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    wrap      = 1'b0;
    iter_next = iter_cnt_q + ITER_WIDTH'(1);
    last_pass = 1'b0;
    // Taking the wrap branch whenever nxt is not below max means max at the
    // top of the pc range never increments past it, and loop > max simply
    // re-emits loop on every slot.
    if (!(nxt < max_q)) begin
      wrap      = 1'b1;
      last_pass = (iters_q != ITER_WIDTH'(ITER_INF)) && (iter_next == iters_q);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the configuration registers are a small flop bank, not a RAM,
      // so they are cleared with everything else to give a defined idle state.
      max_q      <= '0;
      loop_q     <= '0;
      iters_q    <= '0;
      iter_cnt_q <= '0;
      nxt        <= '0;
      active     <= 1'b0;
      done       <= 1'b0;
    end else begin
      // A running context keeps its configuration; writes are dropped.
      if (cfg_we && !active) begin
        max_q   <= cfg_max;
        loop_q  <= cfg_loop;
        iters_q <= cfg_iters;
      end

      if (start && !active) begin
        active     <= 1'b1;
        done       <= 1'b0;
        nxt        <= '0;
        iter_cnt_q <= '0;
      end else if (sel && active) begin
        if (!wrap) begin
          nxt <= nxt + PC_WIDTH'(1);
        end else begin
          nxt        <= loop_q;
          iter_cnt_q <= iter_next;
          // Done lands on the same edge that presents the final max on pc.
          if (last_pass) begin
            active <= 1'b0;
            done   <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/program_counter_mt.sv
// -----------------------------------------------------------------------------
// program_counter_mt
//   Multi-thread program counter for the CGRA PE control path. NUM_THREADS
//   independent contexts (NUM_THREADS >= 2) are served by a fixed rotating
//   time slot, one slot per enabled cycle; the selected context's pc appears
//   on the registered output one cycle later.
// Ports
//   clk, rst     clock / synchronous active-high reset
//   en           advance enable; low freezes slot and all contexts
//   cfg_we       configuration write strobe for thread cfg_tid
//   cfg_tid      thread addressed by the write
//   cfg_max      last pc value of a pass
//   cfg_loop     pc restarted from after max
//   cfg_iters    wraps before done; 0 runs forever
//   start        per-thread start pulse (honoured even when en is low)
//   pc, pc_tid   emitted pc and owning thread (registered, hold when idle)
//   pc_valid     pc/pc_tid carry a fresh emission this cycle
//   thread_done  per-thread sticky done flags
//   all_done     registered AND of thread_done
// -----------------------------------------------------------------------------
module program_counter_mt
  import program_counter_mt_pkg::*;
#(
  parameter  int PC_WIDTH    = 8,
  parameter  int NUM_THREADS = 4,
  parameter  int ITER_WIDTH  = 16,
  localparam int TID_WIDTH   = tid_width(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   cfg_we,
  input  logic [TID_WIDTH-1:0]   cfg_tid,
  input  logic [PC_WIDTH-1:0]    cfg_max,
  input  logic [PC_WIDTH-1:0]    cfg_loop,
  input  logic [ITER_WIDTH-1:0]  cfg_iters,
  input  logic [NUM_THREADS-1:0] start,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [TID_WIDTH-1:0]   pc_tid,
  output logic                   pc_valid,
  output logic [NUM_THREADS-1:0] thread_done,
  output logic                   all_done
);

  logic [TID_WIDTH-1:0]   slot_q;
  logic [NUM_THREADS-1:0] ctx_active;
  logic [PC_WIDTH-1:0]    ctx_nxt [NUM_THREADS];

  for (genvar i = 0; i < NUM_THREADS; i++) begin : g_ctx
    logic sel;
    logic ctx_cfg_we;

    assign sel        = en && (slot_q == TID_WIDTH'(i));
    assign ctx_cfg_we = cfg_we && (cfg_tid == TID_WIDTH'(i));

    pc_thread_ctx #(
      .PC_WIDTH  (PC_WIDTH),
      .ITER_WIDTH(ITER_WIDTH)
    ) u_ctx (
      .clk      (clk),
      .rst      (rst),
      .sel      (sel),
      .start    (start[i]),
      .cfg_we   (ctx_cfg_we),
      .cfg_max  (cfg_max),
      .cfg_loop (cfg_loop),
      .cfg_iters(cfg_iters),
      .active   (ctx_active[i]),
      .done     (thread_done[i]),
      .nxt      (ctx_nxt[i])
    );
  end

  // Slot rotation and registered output mux. The mux samples the context's
  // nxt before that context advances on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= '0;
      pc       <= '0;
      pc_tid   <= '0;
      pc_valid <= 1'b0;
      all_done <= 1'b0;
    end else begin
      all_done <= &thread_done;
      pc_valid <= 1'b0;
      if (en) begin
        slot_q <= (slot_q == TID_WIDTH'(NUM_THREADS - 1)) ? '0 : slot_q + TID_WIDTH'(1);
        if (ctx_active[slot_q]) begin
          pc       <= ctx_nxt[slot_q];
          pc_tid   <= slot_q;
          pc_valid <= 1'b1;
        end
      end
    end
  end

endmodule
